spi_slave_if: RTL and testbench
===============================

# spi_slave_if

SPI slave front-end that deserializes MOSI frames from an external master into 10-bit command/data words for the on-chip single-port memory, and serializes the memory's 8-bit read data back onto MISO. It sits between the chip's SPI pins and the memory block's `din`/`rx_valid` input and `dout`/`tx_valid` output. Mode-0 style: all sampling and driving happens on `clk`, one bit per cycle.

## Interface
- `IDLE_MISO`, default 1'b0: MISO level driven when no read data is being shifted.
- `clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `SS_n` input 1: slave select, active low; frames a transaction.
- `MOSI` input 1: serial data from master, MSB first.
- `rx_data` output 10: captured frame to memory; `[9:8]` command, `[7:0]` address/data.
- `rx_valid` output 1: one-cycle strobe, `rx_data` valid.
- `tx_data` input 8: read data from memory.
- `tx_valid` input 1: `tx_data` valid strobe from memory.
- `MISO` output 1: serial data to master, MSB first.

## Operation
- States:
  - IDLE
  - CHK_CMD
  - WRITE
  - READ
  - READ_WAIT
  - READ_SHIFT
  - WAIT_SS
- IDLE: `SS_n`=0 sampled -> CHK_CMD.
- CHK_CMD: sample `MOSI` as frame bit 9.
  - 0 -> WRITE.
  - 1 -> READ.
- WRITE/READ: sample 9 more bits (8..0) on 9 consecutive edges; a 4-bit counter tracks position.
- Frame completion:
  - `rx_data` updates and `rx_valid`=1 for exactly one cycle, the cycle after bit 0 is captured.
  - `rx_data` holds its value until the next completed frame.
- Next state after frame:
  - `rx_data[9:8]`=11 -> READ_WAIT.
  - Otherwise -> WAIT_SS.
- READ_WAIT: waits for `tx_valid`=1, then captures `tx_data` into an 8-bit shift register and goes to READ_SHIFT. If `tx_valid` never arrives, stays until `SS_n`=1.
- READ_SHIFT: MISO carries `tx_data[7]`..`[0]`, one bit per cycle, 8 cycles, then -> WAIT_SS.
- WAIT_SS: MOSI ignored; `SS_n`=1 -> IDLE.
- `SS_n`=1 sampled in any non-IDLE state aborts:
  - next state IDLE;
  - counter cleared;
  - no `rx_valid` for a partial frame;
  - MISO returns to `IDLE_MISO`.
- `tx_valid` outside READ_WAIT is ignored.
- `rx_valid` and the READ_WAIT transition are never blocked by a simultaneous `SS_n` rise on the bit-0 edge: a complete frame is delivered, then abort applies.
- `rd_addr_seen` flag:
  - set when a frame with `[9:8]`=10 is delivered;
  - cleared when a frame with `[9:8]`=11 is delivered;
  - unaffected by abort.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `MISO`=`IDLE_MISO`, state IDLE, counter 0, shift register 0, `rd_addr_seen`=0.
- Cycle numbering:
  - Edge E0 samples `SS_n`=0 in IDLE.
  - E1 samples bit 9.
  - E2..E10 sample bits 8..0.
  - `rx_valid` is high in the cycle after E10.
- Minimum frame is 11 cycles from the `SS_n` fall.
- Memory response: the memory asserts `tx_valid` one cycle after `rx_valid`.
  - `tx_valid` is sampled at edge T.
  - MISO = bit 7 in the cycle after T; bit 0 seven cycles later.
- Back-to-back frames require `SS_n` high for at least one sampled edge.

## Configuration
- Macro: `SPI_SLAVE_RD_ORDER_CHK_EN`.
- Defined:
  - A `[9:8]`=11 frame received while `rd_addr_seen`=0 is dropped: no `rx_valid`, -> WAIT_SS, MISO stays idle.
  - The frame still updates `rx_data` as usual.
- Undefined: every complete frame is delivered regardless of `rd_addr_seen`. The flag still exists but does not gate anything.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `SS_n`=0 and MOSI toggling -> `rx_valid`=0, `MISO`=0, state IDLE.
- Write address: send 00_1010_0101 -> single `rx_valid` pulse 11 cycles after the `SS_n` fall with `rx_data`=10'h0A5; MISO stays 0.
- Read sequence:
  - Send 10_0011_1100 -> `rx_data`=10'h23C.
  - Then send 11_0000_0000; model `tx_valid`=1 with `tx_data`=8'hB6 one cycle after `rx_valid`.
  - Required: MISO = 1,0,1,1,0,1,1,0 over 8 consecutive cycles starting the cycle after `tx_valid`.
- Abort: raise `SS_n` after 6 bits -> no `rx_valid`; the next full frame 00_0000_0001 yields `rx_data`=10'h001.
- Order check (macro defined): after reset, send 11_0000_0000 -> no `rx_valid`, MISO stays 0. With the macro undefined, the same frame gives `rx_valid`=1 and `rx_data`=10'h300.
- No response: read-data frame with `tx_valid` held 0 for 20 cycles -> stays in READ_WAIT with MISO idle; raising `SS_n` returns to IDLE.

Source files
------------

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front-end for the on-chip single-port memory.
// Deserializes 10-bit MOSI frames (MSB first) into rx_data/rx_valid and
// shifts 8-bit memory read data (tx_data/tx_valid) back out on MISO.
// Optional build macro SPI_SLAVE_RD_ORDER_CHK_EN: when defined, a read-data
// frame (cmd 11) arriving before any read-address frame (cmd 10) is dropped.
module spi_slave_if #(
   parameter logic IDLE_MISO = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       SS_n,
   input  logic       MOSI,
   output logic [9:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       MISO
);

   typedef enum logic [2:0] {
      StIdle,
      StChkCmd,
      StWrite,
      StRead,
      StReadWait,
      StReadShift,
      StWaitSs
   } state_e;

   localparam logic [1:0] CmdRdAddr = 2'b10;
   localparam logic [1:0] CmdRdData = 2'b11;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [8:0] rx_shift_q, rx_shift_d;
   logic [9:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic       miso_q, miso_d;
   logic       rd_addr_seen_q, rd_addr_seen_d;

   // Frame assembled on the bit-0 edge and whether it is handed to memory.
   logic [9:0] frame_w;
   logic       deliver_w;

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign MISO     = miso_q;

   // Decide whether a completed frame reaches the memory.
   always_comb begin
      frame_w   = {rx_shift_q, MOSI};
      deliver_w = 1'b1;
`ifdef SPI_SLAVE_RD_ORDER_CHK_EN
      if (frame_w[9:8] == CmdRdData && !rd_addr_seen_q) begin
         deliver_w = 1'b0;
      end
`else
      deliver_w = 1'b1;
`endif
   end

   // Next-state and registered-output computation for the whole slave.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rx_shift_d     = rx_shift_q;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      tx_shift_d     = tx_shift_q;
      miso_d         = miso_q;
      rd_addr_seen_d = rd_addr_seen_q;

      case (state_q)
         StIdle: begin
            cnt_d  = 4'd0;
            miso_d = IDLE_MISO;
            if (!SS_n) begin
               state_d = StChkCmd;
            end
         end

         StChkCmd: begin
            if (SS_n) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
               miso_d  = IDLE_MISO;
            end else begin
               rx_shift_d = {8'd0, MOSI};
               cnt_d      = 4'd0;
               state_d    = MOSI ? StRead : StWrite;
            end
         end

         StWrite, StRead: begin
            if (cnt_q == 4'd8) begin
               // Bit 0 edge: the frame is complete even if SS_n rises now.
               rx_data_d  = frame_w;
               rx_valid_d = deliver_w;
               cnt_d      = 4'd0;
               if (deliver_w && frame_w[9:8] == CmdRdAddr) begin
                  rd_addr_seen_d = 1'b1;
               end else if (deliver_w && frame_w[9:8] == CmdRdData) begin
                  rd_addr_seen_d = 1'b0;
               end
               if (SS_n) begin
                  state_d = StIdle;
                  miso_d  = IDLE_MISO;
               end else if (deliver_w && frame_w[9:8] == CmdRdData) begin
                  state_d = StReadWait;
               end else begin
                  state_d = StWaitSs;
               end
            end else if (SS_n) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
               miso_d  = IDLE_MISO;
            end else begin
               rx_shift_d = {rx_shift_q[7:0], MOSI};
               cnt_d      = cnt_q + 4'd1;
            end
         end

         StReadWait: begin
            if (SS_n) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
               miso_d  = IDLE_MISO;
            end else if (tx_valid) begin
               // Bit 7 goes straight to MISO; the rest waits in the shifter.
               miso_d     = tx_data[7];
               tx_shift_d = {tx_data[6:0], 1'b0};
               cnt_d      = 4'd0;
               state_d    = StReadShift;
            end
         end

         StReadShift: begin
            if (SS_n) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
               miso_d  = IDLE_MISO;
            end else if (cnt_q == 4'd7) begin
               miso_d  = IDLE_MISO;
               cnt_d   = 4'd0;
               state_d = StWaitSs;
            end else begin
               miso_d     = tx_shift_q[7];
               tx_shift_d = {tx_shift_q[6:0], 1'b0};
               cnt_d      = cnt_q + 4'd1;
            end
         end

         StWaitSs: begin
            miso_d = IDLE_MISO;
            if (SS_n) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end
         end

         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
            miso_d  = IDLE_MISO;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         cnt_q          <= 4'd0;
         rx_shift_q     <= 9'd0;
         rx_data_q      <= 10'd0;
         rx_valid_q     <= 1'b0;
         tx_shift_q     <= 8'd0;
         miso_q         <= IDLE_MISO;
         rd_addr_seen_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         rx_shift_q     <= rx_shift_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         tx_shift_q     <= tx_shift_d;
         miso_q         <= miso_d;
         rd_addr_seen_q <= rd_addr_seen_d;
      end
   end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed frames against a cycle-indexed expectation model.
module tb_spi_slave_if;

   localparam logic IdleMiso = 1'b0;
   localparam int   MaxC     = 1024;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       ss_n     = 1'b1;
   logic       mosi     = 1'b0;
   logic [7:0] tx_data  = 8'd0;
   logic       tx_valid = 1'b0;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic       miso;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   // Expected behaviour, indexed by the edge number that starts each cycle.
   bit         exp_rxv  [MaxC];
   bit         exp_upd  [MaxC];
   logic [9:0] exp_val  [MaxC];
   bit         exp_mset [MaxC];
   logic       exp_mval [MaxC];
   logic [9:0] model_rxd = 10'd0;
   bit         rd_seen   = 1'b0;

   int         pulses      = 0;
   logic [9:0] last_rxd    = 10'd0;
   int         last_rv_cyc = 0;

   int         p0;
   int         e0;
   bit         ok;
   logic [7:0] seen;

   spi_slave_if #(
      .IDLE_MISO (IdleMiso)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (ss_n),
      .MOSI     (mosi),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .MISO     (miso)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (cyc >= 1 && cyc < MaxC) begin
         if (exp_upd[cyc]) model_rxd = exp_val[cyc];
         chk("rx_valid", 32'(rx_valid), 32'(exp_rxv[cyc]));
         chk("rx_data", 32'(rx_data), 32'(model_rxd));
         chk("miso", 32'(miso), 32'(exp_mset[cyc] ? exp_mval[cyc] : IdleMiso));
         if (rx_valid === 1'b1) begin
            pulses++;
            last_rxd    = rx_data;
            last_rv_cyc = cyc;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A completed frame always updates rx_data; delivery follows the order rule.
   task automatic deliver(input logic [9:0] w, input int e, output bit d);
      d = 1'b1;
`ifdef SPI_SLAVE_RD_ORDER_CHK_EN
      if (w[9:8] == 2'b11 && !rd_seen) d = 1'b0;
`endif
      if (e < MaxC) begin
         exp_upd[e] = 1'b1;
         exp_val[e] = w;
         exp_rxv[e] = d;
      end
      if (d && w[9:8] == 2'b10) rd_seen = 1'b1;
      if (d && w[9:8] == 2'b11) rd_seen = 1'b0;
   endtask

   task automatic send(input logic [9:0] w, input int nbits, input bit rise_on_b0,
                       output int fall_edge, output bit d);
      ss_n = 1'b0;
      mosi = 1'b0;
      step();
      fall_edge = cyc;
      d = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         mosi = w[9-i];
         if (rise_on_b0 && i == 9) ss_n = 1'b1;
         step();
      end
      mosi = 1'b0;
      if (nbits == 10) deliver(w, cyc, d);
   endtask

   task automatic end_frame();
      ss_n = 1'b1;
      mosi = 1'b0;
      step();
      step();
   endtask

   // Memory answers one cycle after rx_valid; optionally abort after n bits.
   task automatic respond(input logic [7:0] d, input int n, output logic [7:0] got);
      int t;
      step();
      tx_valid = 1'b1;
      tx_data  = d;
      step();
      tx_valid = 1'b0;
      tx_data  = 8'd0;
      t = cyc;
      for (int k = 0; k < n; k++) begin
         if (t + k < MaxC) begin
            exp_mset[t+k] = 1'b1;
            exp_mval[t+k] = d[7-k];
         end
      end
      got = 8'd0;
      for (int k = 0; k < n; k++) begin
         got[7-k] = miso;
         if (k == n - 1 && n < 8) ss_n = 1'b1;
         step();
      end
   endtask

   initial begin
      // Reset held two edges with SS_n low and MOSI toggling.
      rst_n = 1'b0;
      ss_n  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mosi = ~mosi;
         step();
      end
      rst_n = 1'b1;
      ss_n  = 1'b1;
      mosi  = 1'b0;
      step();
      chk("reset_rx_valid", 32'(rx_valid), 32'd0);
      chk("reset_miso", 32'(miso), 32'd0);
      chk("reset_rx_data", 32'(rx_data), 32'h000);

      // Read-data frame straight after reset.
      p0 = pulses;
      send(10'h300, 10, 1'b0, e0, ok);
      end_frame();
`ifdef SPI_SLAVE_RD_ORDER_CHK_EN
      chk("order_pulses", 32'(pulses - p0), 32'd0);
`else
      chk("order_pulses", 32'(pulses - p0), 32'd1);
      chk("order_rxd", 32'(last_rxd), 32'h300);
`endif
      chk("order_rx_data", 32'(rx_data), 32'h300);

      // Write address, then a stray tx_valid that must be ignored.
      p0 = pulses;
      send(10'h0A5, 10, 1'b0, e0, ok);
      step();
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      step();
      tx_valid = 1'b0;
      tx_data  = 8'd0;
      step();
      end_frame();
      chk("write_pulses", 32'(pulses - p0), 32'd1);
      chk("write_rxd", 32'(last_rxd), 32'h0A5);
      chk("write_latency", 32'(last_rv_cyc - e0), 32'd10);

      // Read address then read data with a full response.
      send(10'h23C, 10, 1'b0, e0, ok);
      end_frame();
      chk("rdaddr_rxd", 32'(last_rxd), 32'h23C);
      send(10'h300, 10, 1'b0, e0, ok);
      respond(8'hB6, 8, seen);
      end_frame();
      chk("rddata_rxd", 32'(last_rxd), 32'h300);
      chk("read_miso_bits", 32'(seen), 32'hB6);

      // Abort after 6 bits, then a clean frame.
      p0 = pulses;
      send(10'h155, 6, 1'b0, e0, ok);
      end_frame();
      chk("abort_pulses", 32'(pulses - p0), 32'd0);
      send(10'h001, 10, 1'b0, e0, ok);
      end_frame();
      chk("after_abort_rxd", 32'(last_rxd), 32'h001);

      // SS_n rising on the bit-0 edge still delivers; next frame follows at once.
      p0 = pulses;
      send(10'h2A5, 10, 1'b1, e0, ok);
      step();
      send(10'h0C3, 10, 1'b0, e0, ok);
      end_frame();
      chk("b0_rise_pulses", 32'(pulses - p0), 32'd2);
      chk("b0_rise_next_rxd", 32'(last_rxd), 32'h0C3);

      // Read response cut short after 3 bits.
      send(10'h2FF, 10, 1'b0, e0, ok);
      end_frame();
      send(10'h3AA, 10, 1'b0, e0, ok);
      respond(8'h5C, 3, seen);
      end_frame();
      chk("partial_miso_bits", 32'(seen), 32'h40);

      // No memory response for 20 cycles, then release and a fresh frame.
      send(10'h280, 10, 1'b0, e0, ok);
      end_frame();
      send(10'h300, 10, 1'b0, e0, ok);
      for (int i = 0; i < 20; i++) step();
      end_frame();
      send(10'h0F0, 10, 1'b0, e0, ok);
      end_frame();
      chk("noresp_next_rxd", 32'(last_rxd), 32'h0F0);
      chk("noresp_next_latency", 32'(last_rv_cyc - e0), 32'd10);

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
